id_regfile_scoreboard: RTL and testbench
========================================

// Module: id_regfile_scoreboard
// PURPOSE
//  Decode-stage register file for the pipelined RV32I core; the parametrised successor to the single-read-pair regfile.
//  Provides NUM_RD combinational read ports with write-through bypass from the write-back stage.
//  Holds a per-register pending-write scoreboard so decode can detect RAW hazards and stall.
//  Sits between IF/ID buffer (read addresses) and MEM/WB buffer (write-back); issue is driven from ID/EX load.
// PARAMETERS
//  XLEN      32  data width of each register
//  NUM_REGS  32  architectural registers; index 0 hardwired to zero; AW = $clog2(NUM_REGS)
//  NUM_RD    2   number of independent read ports
//  MAX_PEND  3   max outstanding writes tracked per register; CW = $clog2(MAX_PEND+1)
// PORTS
//  clk            in   1            clock, all state updates on rising edge
//  rst            in   1            synchronous reset, active-low (0 = reset)
//  rd_addr_i      in   NUM_RD*AW    read addresses, port i at [i*AW +: AW]
//  rd_data_o      out  NUM_RD*XLEN  read data, port i at [i*XLEN +: XLEN]
//  rd_busy_o      out  NUM_RD       1 = port i register has an outstanding write not yet available
//  issue_valid_i  in   1            instruction with destination leaves decode this cycle
//  issue_rd_i     in   AW           its destination register
//  issue_ready_o  out  1            0 = issue_rd_i counter saturated; decode must stall
//  wb_valid_i     in   1            write-back this cycle
//  wb_rd_i        in   AW           write-back destination
//  wb_data_i      in   XLEN         write-back data (already formatted/extended upstream)
//  flush_i        in   1            pipeline flush: clear all pending counters
// BEHAVIOUR
//  Reset (rst==0 at edge): all registers <= 0, all counters <= 0. Thereafter rd_data_o=0, rd_busy_o=0, issue_ready_o=1.
//  Write: at edge, if wb_valid_i && wb_rd_i!=0, reg[wb_rd_i] <= wb_data_i. Writes to x0 discarded.
//  Read (comb, 0 latency): addr==0 -> 0; else if wb_valid_i && wb_rd_i==addr -> wb_data_i (bypass);
//   else reg[addr]. All ports independent; any number may alias the same register.
//  Scoreboard: cnt[r] CW bits per register, cnt[0] constant 0.
//   inc = issue_valid_i && issue_ready_o && issue_rd_i==r && r!=0
//   dec = wb_valid_i && wb_rd_i==r && r!=0 && cnt[r]!=0
//   cnt[r] <= cnt[r] + inc - dec at edge; inc&dec same cycle -> unchanged.
//   dec never underflows: wb to a register with cnt==0 writes data, counter stays 0.
//  issue_ready_o = (issue_rd_i==0) || cnt[issue_rd_i]!=MAX_PEND; combinational, independent of issue_valid_i.
//   Issue while not ready is ignored (no increment); issue to x0 always ready, never counted.
//  rd_busy_o[i] = addr!=0 && (cnt[addr]>1 || (cnt[addr]==1 && !(wb_valid_i && wb_rd_i==addr))).
//   i.e. last pending write arriving this cycle is visible via bypass, so not busy.
//  flush_i: all cnt <= 0 at edge, overrides inc/dec that cycle; the register write still happens.
//   Late write-backs after flush write data normally and leave cnt at 0.
//  Reset has priority over flush, write and issue; reset mid-operation drops all pending state.
//  No X on outputs for any in-range address; out-of-range addresses (>=NUM_REGS) read 0, busy 0.
// TESTING
//  1 Reset: hold rst=0 2 cycles, release -> all rd_data_o=0, rd_busy_o=0, issue_ready_o=1.
//  2 Bypass: wb x5=0xDEADBEEF, rd_addr port0=5 same cycle -> rd_data_o[0]=0xDEADBEEF comb; next cycle still 0xDEADBEEF from array.
//  3 x0: wb x0=0x1234, issue x0 x4 -> read x0 = 0, busy 0, ready 1 throughout.
//  4 Scoreboard: issue x7 three times -> busy=1, issue_ready_o=0 for x7; 4th issue ignored;
//    3 wb to x7 -> busy stays 1 until cycle of third wb (busy 0 that cycle, data bypassed).
//  5 Simultaneous: cnt[x3]=1, issue x3 and wb x3 same cycle -> cnt stays 1, busy next cycle =1.
//  6 Flush/reset: issue x9 twice, flush_i=1 -> busy 0 next cycle; later wb x9=0x55 writes data, cnt 0;
//    assert rst=0 mid-sequence -> all state cleared next cycle.

Source files
------------

// File: rtl/id_regfile_scoreboard.sv
// Decode-stage register file: NUM_RD combinational read ports with write-back
// bypass, plus a per-register pending-write scoreboard for RAW hazard stalls.
module id_regfile_scoreboard #(
  parameter  int XLEN     = 32,
  parameter  int NUM_REGS = 32,
  parameter  int NUM_RD   = 2,
  parameter  int MAX_PEND = 3,
  localparam int AW       = $clog2(NUM_REGS),
  localparam int CW       = $clog2(MAX_PEND + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rd_addr_i,
  output logic [NUM_RD*XLEN-1:0] rd_data_o,
  output logic [NUM_RD-1:0]      rd_busy_o,
  input  logic                   issue_valid_i,
  input  logic [AW-1:0]          issue_rd_i,
  output logic                   issue_ready_o,
  input  logic                   wb_valid_i,
  input  logic [AW-1:0]          wb_rd_i,
  input  logic [XLEN-1:0]        wb_data_i,
  input  logic                   flush_i
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PEND);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic [CW-1:0]   cnt  [NUM_REGS];

  // A "live" address names a real, writable register: not x0 and in range.
  function automatic logic live(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NUM_REGS);
  endfunction

  always_comb begin
    issue_ready_o = 1'b1;
    if (live(issue_rd_i)) issue_ready_o = (cnt[issue_rd_i] != MAX_CNT);
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          live_a;
    logic          hit;

    assign addr   = rd_addr_i[i*AW +: AW];
    assign live_a = live(addr);
    assign hit    = wb_valid_i && (wb_rd_i == addr);

    assign rd_data_o[i*XLEN +: XLEN] = !live_a ? '0 : (hit ? wb_data_i : regs[addr]);
    // The final outstanding write landing this cycle is already bypassed, so not busy.
    assign rd_busy_o[i] = live_a && ((cnt[addr] > ONE) || ((cnt[addr] == ONE) && !hit));
  end

  // NOTE: non-blocking assignments keep every register/counter update in this
  // block reading pre-edge values, so issue/write-back ordering never matters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the array is reset on purpose; reads of never-written registers
      // must return 0, which rules out a plain reset-less RAM here.
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
    end else begin
      if (wb_valid_i && live(wb_rd_i)) regs[wb_rd_i] <= wb_data_i;

      for (int r = 1; r < NUM_REGS; r++) begin
        if (flush_i) begin
          cnt[r] <= '0;
        end else begin
          if (issue_valid_i && issue_ready_o && (issue_rd_i == AW'(r))
              && !(wb_valid_i && (wb_rd_i == AW'(r)) && (cnt[r] != '0)))
            cnt[r] <= cnt[r] + ONE;
          else if (wb_valid_i && (wb_rd_i == AW'(r)) && (cnt[r] != '0)
                   && !(issue_valid_i && issue_ready_o && (issue_rd_i == AW'(r))))
            cnt[r] <= cnt[r] - ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// Directed, table-driven bench for id_regfile_scoreboard: bypass, x0, scoreboard
// saturation, simultaneous issue/write-back, flush and mid-run reset.
module tb_id_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  a0, a1;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        iv, ready, wv, fl;
  logic [4:0]  ird, wrd;
  logic [31:0] wdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_regfile_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .rd_addr_i    ({a1, a0}),
    .rd_data_o    (rd_data),
    .rd_busy_o    (rd_busy),
    .issue_valid_i(iv),
    .issue_rd_i   (ird),
    .issue_ready_o(ready),
    .wb_valid_i   (wv),
    .wb_rd_i      (wrd),
    .wb_data_i    (wdata),
    .flush_i      (fl)
  );

  typedef struct {
    logic [4:0]  a0, a1;
    logic        iv;
    logic [4:0]  ird;
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic        fl;
    logic [31:0] e_d0, e_d1;
    logic [1:0]  e_busy;
    logic        e_ready;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [4:0] p0, input logic [4:0] p1,
                     input logic i_v, input logic [4:0] i_rd,
                     input logic w_v, input logic [4:0] w_rd, input logic [31:0] w_d,
                     input logic f,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input logic [1:0] b, input logic r);
    vec_t v;
    v.a0 = p0; v.a1 = p1; v.iv = i_v; v.ird = i_rd; v.wv = w_v; v.wrd = w_rd;
    v.wdata = w_d; v.fl = f; v.e_d0 = d0; v.e_d1 = d1; v.e_busy = b; v.e_ready = r;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] p0, input logic [4:0] p1,
                       input logic i_v, input logic [4:0] i_rd,
                       input logic w_v, input logic [4:0] w_rd, input logic [31:0] w_d,
                       input logic f);
    a0 = p0; a1 = p1; iv = i_v; ird = i_rd; wv = w_v; wrd = w_rd; wdata = w_d; fl = f;
  endtask

  // Check combinational outputs mid-cycle, before the edge that commits this cycle.
  task automatic check_outs(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [1:0] b, input logic r);
    #2;
    check({tag, " data0"}, rd_data[31:0], d0);
    check({tag, " data1"}, rd_data[63:32], d1);
    check({tag, " busy"},  {30'd0, rd_busy}, {30'd0, b});
    check({tag, " ready"}, {31'd0, ready}, {31'd0, r});
  endtask

  initial begin
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);

    //   a0  a1  iv ird  wv wrd  wdata         fl  e_d0          e_d1          busy   rdy
    add(5,  7,  0, 7,   0, 0,   32'h0,        0,  32'h0,        32'h0,        2'b00, 1); // post-reset
    add(5,  0,  0, 0,   1, 5,   32'hDEADBEEF, 0,  32'hDEADBEEF, 32'h0,        2'b00, 1); // bypass
    add(5,  5,  0, 0,   0, 0,   32'h0,        0,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1); // from array
    add(0,  0,  1, 0,   1, 0,   32'h1234,     0,  32'h0,        32'h0,        2'b00, 1); // x0 wb+issue
    add(0,  0,  1, 0,   0, 0,   32'h0,        0,  32'h0,        32'h0,        2'b00, 1); // x0 issue
    add(7,  5,  1, 7,   0, 0,   32'h0,        0,  32'h0,        32'hDEADBEEF, 2'b00, 1); // x7 cnt 0
    add(7,  0,  1, 7,   0, 0,   32'h0,        0,  32'h0,        32'h0,        2'b01, 1); // x7 cnt 1
    add(0,  7,  1, 7,   0, 0,   32'h0,        0,  32'h0,        32'h0,        2'b10, 1); // x7 cnt 2
    add(7,  7,  1, 7,   0, 0,   32'h0,        0,  32'h0,        32'h0,        2'b11, 0); // sat, ignored
    add(7,  0,  0, 7,   1, 7,   32'h11,       0,  32'h11,       32'h0,        2'b01, 0); // wb 1 of 3
    add(7,  0,  0, 7,   1, 7,   32'h22,       0,  32'h22,       32'h0,        2'b01, 1); // wb 2 of 3
    add(7,  7,  0, 7,   1, 7,   32'h33,       0,  32'h33,       32'h33,       2'b00, 1); // last wb
    add(7,  0,  0, 7,   0, 0,   32'h0,        0,  32'h33,       32'h0,        2'b00, 1); // cnt 0
    add(3,  0,  1, 3,   0, 0,   32'h0,        0,  32'h0,        32'h0,        2'b00, 1); // x3 cnt 0->1
    add(3,  0,  1, 3,   1, 3,   32'hA5A5,     0,  32'hA5A5,     32'h0,        2'b00, 1); // inc+dec
    add(3,  0,  0, 0,   0, 0,   32'h0,        0,  32'hA5A5,     32'h0,        2'b01, 1); // still 1
    add(3,  0,  0, 0,   1, 3,   32'h5A,       0,  32'h5A,       32'h0,        2'b00, 1); // drain x3
    add(9,  3,  1, 9,   0, 0,   32'h0,        0,  32'h0,        32'h5A,       2'b00, 1); // x9 cnt 0
    add(9,  3,  1, 9,   0, 0,   32'h0,        0,  32'h0,        32'h5A,       2'b01, 1); // x9 cnt 1
    add(9,  0,  1, 9,   0, 0,   32'h0,        1,  32'h0,        32'h0,        2'b01, 1); // flush
    add(9,  0,  0, 9,   0, 0,   32'h0,        0,  32'h0,        32'h0,        2'b00, 1); // cleared
    add(9,  9,  0, 9,   1, 9,   32'h55,       0,  32'h55,       32'h55,       2'b00, 1); // late wb
    add(9,  0,  1, 9,   0, 0,   32'h0,        0,  32'h55,       32'h0,        2'b00, 1); // no underflow
    add(0,  9,  0, 9,   0, 0,   32'h0,        0,  32'h0,        32'h55,       2'b10, 1); // cnt 1

    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k].a0, vecs[k].a1, vecs[k].iv, vecs[k].ird,
            vecs[k].wv, vecs[k].wrd, vecs[k].wdata, vecs[k].fl);
      check_outs($sformatf("vec%0d", k), vecs[k].e_d0, vecs[k].e_d1,
                 vecs[k].e_busy, vecs[k].e_ready);
    end

    // Flush together with a write-back: data lands, counter still cleared.
    @(negedge clk); drive(5'd9, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h66, 1'b1);
    check_outs("flush_wb", 32'h66, 32'h0, 2'b00, 1'b1);
    @(negedge clk); drive(5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
    check_outs("flush_wb_after", 32'h66, 32'h0, 2'b00, 1'b1);

    // Build up pending state, then reset mid-operation with activity on the inputs.
    @(negedge clk); drive(5'd0, 5'd0, 1'b1, 5'd12, 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk); drive(5'd0, 5'd0, 1'b1, 5'd12, 1'b1, 5'd13, 32'h77, 1'b0);
    @(negedge clk); drive(5'd13, 5'd12, 1'b0, 5'd12, 1'b0, 5'd0, 32'h0, 1'b0);
    check_outs("pre_reset", 32'h77, 32'h0, 2'b10, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drive(5'd0, 5'd0, 1'b1, 5'd12, 1'b1, 5'd14, 32'hFF, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    drive(5'd13, 5'd12, 1'b0, 5'd12, 1'b0, 5'd0, 32'h0, 1'b0);
    check_outs("post_reset_a", 32'h0, 32'h0, 2'b00, 1'b1);
    @(negedge clk); drive(5'd14, 5'd5, 1'b0, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0);
    check_outs("post_reset_b", 32'h0, 32'h0, 2'b00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
